// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg: opcode/state enums and parameter legality check for the mul/div unit
package mips_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_e;

    function automatic bit mul_bits_ok(int w, int m);
        return (m == 1 || m == 2 || m == 4) && w % m == 0 && w >= 8 && w % 2 == 0;
    endfunction

endpackage

// File: rtl/mips_div_step.sv
// mips_div_step: one restoring-divide step on magnitudes
//   rem    in  WIDTH  partial remainder
//   bit_in in  1      next dividend bit shifted in
//   dvsr   in  WIDTH  divisor magnitude
//   rem_n  out WIDTH  next partial remainder
//   q      out 1      quotient bit
module mips_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH-1:0] rem_n,
    output logic             q
);
    logic [WIDTH:0] sh;
    assign sh    = {rem, bit_in};
    assign q     = sh >= {1'b0, dvsr};
    // a zero divisor always "subtracts", so the dividend bits simply stream into rem
    assign rem_n = WIDTH'(q ? sh - {1'b0, dvsr} : sh);
endmodule

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MIPS multiply/divide unit owning HI/LO
//   clk, reset (sync, active-high); start/op/src_a/src_b request; flush aborts in-flight op
//   ready/busy idle status; done result pulse; div0 sticky divide-by-zero; hi/lo registers
//   MULDIV_EARLY_OUT_EN: multiply stops once remaining multiplier magnitude is zero
import mips_muldiv_pkg::*;
module mips_muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  op_e              op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int W2 = 2 * WIDTH;

    if (!mul_bits_ok(WIDTH, MUL_BITS)) begin : g_bad_cfg
        $error("mips_muldiv_unit: illegal WIDTH/MUL_BITS");
    end

    state_e state, state_n;
    logic [CW-1:0] cnt;
    logic [W2-1:0] acc, mcand, part;
    logic [WIDTH-1:0] mplier, rem, quot, dvsr, rem_n, a_mag, b_mag;
    logic q_bit, neg_q, neg_r, is_div, accept, sgn, a_neg, b_neg, op_mul, op_div, mul_last;

    assign ready  = state == IDLE;
    assign busy   = !ready;
    assign accept = start && ready && !flush;
    assign op_mul = op == OP_MULT || op == OP_MULTU;
    assign op_div = op == OP_DIV || op == OP_DIVU;
    assign sgn    = op == OP_MULT || op == OP_DIV;
    assign a_neg  = sgn && src_a[WIDTH-1];
    assign b_neg  = sgn && src_b[WIDTH-1];
    assign a_mag  = a_neg ? -src_a : src_a;
    assign b_mag  = b_neg ? -src_b : src_b;

    always_comb begin
        part = '0;
        for (int i = 0; i < MUL_BITS; i++)
            if (mplier[i]) part = part + (mcand << i);
    end

`ifdef MULDIV_EARLY_OUT_EN
    assign mul_last = (mplier >> MUL_BITS) == '0;
`else
    assign mul_last = cnt == CW'(1);
`endif

    mips_div_step #(.WIDTH(WIDTH)) u_step (
        .rem   (rem),
        .bit_in(quot[WIDTH-1]),
        .dvsr  (dvsr),
        .rem_n (rem_n),
        .q     (q_bit)
    );

    always_comb begin
        state_n = flush ? IDLE :
                  state == IDLE ? (accept && op_mul ? MUL : accept && op_div ? DIV : IDLE) :
                  state == MUL  ? (mul_last ? FIX : MUL) :
                  state == DIV  ? (cnt == CW'(1) ? FIX : DIV) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            div0  <= 1'b0;
        end else begin
            state <= state_n;
            done  <= state == FIX && !flush;
            if (accept) div0 <= 1'b0;
            if (accept && op == OP_MTHI) hi <= src_a;
            if (accept && op == OP_MTLO) lo <= src_a;
            if (state == FIX && !flush) begin
                if (is_div) begin
                    lo   <= neg_q ? -quot : quot;
                    hi   <= neg_r ? -rem : rem;
                    div0 <= dvsr == '0;
                end else begin
                    {hi, lo} <= neg_q ? -acc : acc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cnt    <= op_mul ? CW'(WIDTH / MUL_BITS) : CW'(WIDTH);
            acc    <= '0;
            mcand  <= W2'(a_mag);
            mplier <= b_mag;
            rem    <= '0;
            quot   <= a_mag;
            dvsr   <= b_mag;
            is_div <= op_div;
            // a zero divisor keeps the all-ones quotient unsigned; hi recovers src_a via neg_r
            neg_q  <= (a_neg ^ b_neg) && !(op_div && src_b == '0);
            neg_r  <= a_neg;
        end else if (state == MUL) begin
            acc    <= acc + part;
            mcand  <= mcand << MUL_BITS;
            mplier <= mplier >> MUL_BITS;
            cnt    <= cnt - CW'(1);
        end else if (state == DIV) begin
            rem    <= rem_n;
            quot   <= {quot[WIDTH-2:0], q_bit};
            cnt    <= cnt - CW'(1);
        end
    end
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit: randomized self-checking bench against an arithmetic reference model
import mips_muldiv_pkg::*;
module tb_mips_muldiv_unit;
    localparam int W  = 32;
    localparam int MB = 4;

    logic clk, reset, start, flush, ready, busy, done, div0;
    op_e op;
    logic [W-1:0] src_a, src_b, hi, lo;
    logic [W-1:0] m_hi, m_lo;
    logic m_div0;
    int n_cmp, n_bad;

    mips_muldiv_unit #(.WIDTH(W), .MUL_BITS(MB)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .ready(ready), .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ref_res(op_e o, logic [31:0] a, logic [31:0] b);
        longint sa, sb;
        int qa, qb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        qa = $signed(a);
        qb = $signed(b);
        case (o)
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_MULT:  return sa * sb;
            OP_DIVU:  return b == 0 ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(qa % qb), 32'(qa / qb)};
            end
        endcase
    endfunction

    function automatic int ref_lat(op_e o, logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        logic [31:0] m;
        int n;
        if (o == OP_DIV || o == OP_DIVU) return W + 1;
        m = (o == OP_MULT && b[31]) ? -b : b;
        n = 0;
        for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
        n = (n + MB - 1) / MB;
        return n < 1 ? 2 : n + 1;
`else
        if (o == OP_DIV || o == OP_DIVU) return W + 1;
        return W / MB + 1;
`endif
    endfunction

    task automatic run_op(input op_e o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        int lat, c;
        logic held;
        start = 1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 0; src_a = $urandom; src_b = $urandom;
        m_div0 = 0;
        if (o == OP_MTHI || o == OP_MTLO) begin
            if (o == OP_MTHI) m_hi = a; else m_lo = a;
            n_cmp++;
            if (hi !== m_hi || lo !== m_lo || ready !== 1 || done !== 0 || div0 !== 0) begin
                n_bad++;
                $display("FAIL %s: hi=%h lo=%h rdy=%b done=%b div0=%b need hi=%h lo=%h rdy=1 done=0 div0=0",
                         o.name(), hi, lo, ready, done, div0, m_hi, m_lo);
            end
            return;
        end
        n_cmp++;
        if (busy !== 1 || done !== 0) begin
            n_bad++;
            $display("FAIL accept %s: busy=%b done=%b need busy=1 done=0", o.name(), busy, done);
        end
        lat = ref_lat(o, b);
        r = ref_res(o, a, b);
        held = 1; c = 0;
        while (c < 100 && done !== 1) begin
            if (hi !== m_hi || lo !== m_lo) held = 0;
            @(posedge clk); #1;
            c++;
        end
        n_cmp++;
        if (c != lat) begin
            n_bad++;
            $display("FAIL latency %s a=%h b=%h: got %0d need %0d", o.name(), a, b, c, lat);
        end
        n_cmp++;
        if (!held) begin
            n_bad++;
            $display("FAIL hold %s: hi/lo changed mid-op, need %h/%h", o.name(), m_hi, m_lo);
        end
        m_hi = r[63:32];
        m_lo = r[31:0];
        m_div0 = (o == OP_DIV || o == OP_DIVU) && b == 0;
        n_cmp++;
        if (hi !== m_hi || lo !== m_lo || div0 !== m_div0 || ready !== 1 || busy !== 0) begin
            n_bad++;
            $display("FAIL result %s a=%h b=%h: hi=%h lo=%h div0=%b rdy=%b busy=%b need hi=%h lo=%h div0=%b rdy=1 busy=0",
                     o.name(), a, b, hi, lo, div0, ready, busy, m_hi, m_lo, m_div0);
        end
    endtask

    task automatic test_reset();
        reset = 1; start = 0; flush = 0; op = OP_MULT; src_a = '1; src_b = '1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        m_hi = 0; m_lo = 0; m_div0 = 0;
        n_cmp++;
        if (hi !== 0 || lo !== 0 || ready !== 1 || busy !== 0 || done !== 0 || div0 !== 0) begin
            n_bad++;
            $display("FAIL reset: hi=%h lo=%h rdy=%b busy=%b done=%b div0=%b need 0/0/1/0/0/0",
                     hi, lo, ready, busy, done, div0);
        end
    endtask

    task automatic test_directed();
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        run_op(OP_MULTU, 32'd9, 32'd1);
        run_op(OP_MULT, 32'd5, 32'd0);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(OP_DIVU, 32'd5, 32'd0);
        run_op(OP_MTLO, 32'h0000_1234, 32'd0);
        run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0);
        run_op(OP_MTHI, 32'h0000_BEEF, 32'd0);
    endtask

    task automatic test_flush();
        logic seen;
        int k;
        run_op(OP_MTHI, 32'h0000_A5A5, 32'd0);
        for (int t = 0; t < 4; t++) begin
            op_e o;
            o = t == 0 ? OP_MULTU : OP_DIV;
            k = t == 0 ? 6 : t == 1 ? W : $urandom_range(1, W);
            start = 1; op = o; src_a = $urandom; src_b = 32'hFFFF_FFFF;
            @(posedge clk); #1;
            start = 0; m_div0 = 0; seen = 0;
            for (int c = 1; c <= k; c++) begin
                start = c == 3; op = OP_MTLO; src_a = 32'h0000_DEAD;
                @(posedge clk); #1;
                if (done === 1) seen = 1;
            end
            start = 0; flush = 1;
            @(posedge clk); #1;
            flush = 0;
            n_cmp++;
            if (ready !== 1 || busy !== 0 || hi !== m_hi || lo !== m_lo || div0 !== m_div0 || done !== 0 || seen) begin
                n_bad++;
                $display("FAIL flush %s k=%0d: rdy=%b busy=%b hi=%h lo=%h div0=%b done=%b seen=%b need rdy=1 busy=0 hi=%h lo=%h div0=%b done=0",
                         o.name(), k, ready, busy, hi, lo, div0, done, seen, m_hi, m_lo, m_div0);
            end
            repeat (3) begin
                @(posedge clk); #1;
                if (done === 1) seen = 1;
            end
            n_cmp++;
            if (seen || lo !== m_lo) begin
                n_bad++;
                $display("FAIL flush_after %s: done seen=%b lo=%h need seen=0 lo=%h", o.name(), seen, lo, m_lo);
            end
        end
        start = 1; flush = 1; op = OP_MTHI; src_a = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        start = 0; flush = 0;
        n_cmp++;
        if (hi !== m_hi || ready !== 1) begin
            n_bad++;
            $display("FAIL idle_flush_start: hi=%h rdy=%b need hi=%h rdy=1", hi, ready, m_hi);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        run_op(OP_MULT, 32'h1234_5678, 32'h0765_4321);
        start = 1; op = OP_DIV; src_a = 32'h7777_0000; src_b = 32'd3;
        @(posedge clk); #1;
        start = 0;
        repeat (4) @(posedge clk);
        #1 reset = 1; flush = 1;
        @(posedge clk); #1;
        reset = 0; flush = 0;
        m_hi = 0; m_lo = 0; m_div0 = 0;
        n_cmp++;
        if (hi !== 0 || lo !== 0 || ready !== 1 || done !== 0 || div0 !== 0) begin
            n_bad++;
            $display("FAIL reset_mid: hi=%h lo=%h rdy=%b done=%b div0=%b need 0/0/1/0/0", hi, lo, ready, done, div0);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1 || ready !== 1) seen = 1;
        end
        n_cmp++;
        if (seen || hi !== 0 || lo !== 0) begin
            n_bad++;
            $display("FAIL reset_after: stray activity=%b hi=%h lo=%h need 0/0/0", seen, hi, lo);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return 32'($urandom_range(0, 255)) << $urandom_range(0, 24);
            default: return $urandom;
        endcase
    endfunction

    task automatic test_back_to_back();
        for (int n = 0; n < 60; n++)
            run_op(op_e'($urandom_range(0, 5)), pick(), pick());
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        test_reset();
        test_directed();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
